bpd1: RTL and testbench

BPD1 -- requirements
Module: bpd1

---
 rtl/bpd1.sv | 155 +++++++++++++++
 tb/tb_bpd1.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bpd1.sv
// rtl/bpd1.sv - tournament direction predictor: 3-bit local PHT, 2-bit global PHT, speculative GHR, init sweep
module bpd1 #(
  parameter int LHISTW = 10,
  parameter int GHISTW = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_fetch_i,
  input  logic              br_valid_f1_i,
  input  logic              bpd_pht_choice_f1,
  input  logic [LHISTW-1:0] bpd_bht_lochist_f1,
  input  logic              bpd_rt_we_i,
  input  logic              bpd_rt_brdir_i,
  input  logic [LHISTW-1:0] bpd_rt_lochist_i,
  input  logic [GHISTW-1:0] bpd_rt_ghist_i,
  input  logic              bpd_rt_lpred_i,
  input  logic              bpd_rt_gpred_i,
  input  logic              bpd_flush_i,
  input  logic [GHISTW-1:0] bpd_flush_ghist_i,
  input  logic              bpd_flush_brdir_i,
  output logic              bpd_pred_valid_f2,
  output logic              bpd_pred_taken_f2,
  output logic              bpd_lpred_f2,
  output logic              bpd_gpred_f2,
  output logic [GHISTW-1:0] bpd_ghist_f2,
  output logic              bpd_ch_we_o,
  output logic              bpd_ch_brdir_o,
  output logic              bpd_ready_o
);

  localparam int LENT = 1 << LHISTW;
  localparam int GENT = 1 << GHISTW;

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [GHISTW-1:0] cnt_q, cnt_d;
  logic [GHISTW-1:0] ghr_q, ghr_d;
  logic [GHISTW-1:0] ghist_f2_q, ghist_f2_d;
  logic              valid_f2_q, valid_f2_d;
  logic              taken_f2_q, taken_f2_d;
  logic              lpred_f2_q, lpred_f2_d;
  logic              gpred_f2_q, gpred_f2_d;

  logic [2:0] local_pht  [LENT];
  logic [1:0] global_pht [GENT];

  logic       ready;
  logic       init_we;
  logic       rt_upd;
  logic       lpred_f1, gpred_f1, pred_f1;
  logic [2:0] loc_old, loc_new;
  logic [1:0] glb_old, glb_new;

  assign ready = (state_q == RUN);

  // Combinational reads see the pre-write value; a same-cycle retire lands at the edge.
  assign lpred_f1 = local_pht[bpd_bht_lochist_f1][2];
  assign gpred_f1 = global_pht[ghr_q][1];
  assign pred_f1  = bpd_pht_choice_f1 ? gpred_f1 : lpred_f1;

  assign rt_upd  = bpd_rt_we_i & ready;
  assign loc_old = local_pht[bpd_rt_lochist_i];
  assign glb_old = global_pht[bpd_rt_ghist_i];

  always_comb begin
    loc_new = loc_old;
    glb_new = glb_old;
    if (bpd_rt_brdir_i) begin
      if (loc_old != 3'd7) loc_new = loc_old + 3'd1;
      if (glb_old != 2'd3) glb_new = glb_old + 2'd1;
    end else begin
      if (loc_old != 3'd0) loc_new = loc_old - 3'd1;
      if (glb_old != 2'd0) glb_new = glb_old - 2'd1;
    end
  end

  // The sweep covers the larger global table; the local table wraps on the low bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + GHISTW'(1);
        if (&cnt_q) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    ghr_d      = ghr_q;
    valid_f2_d = valid_f2_q;
    taken_f2_d = taken_f2_q;
    lpred_f2_d = lpred_f2_q;
    gpred_f2_d = gpred_f2_q;
    ghist_f2_d = ghist_f2_q;
    if (bpd_flush_i) begin
      ghr_d      = GHISTW'({bpd_flush_ghist_i, bpd_flush_brdir_i});
      valid_f2_d = 1'b0;
    end else if (load_fetch_i && ready) begin
      valid_f2_d = br_valid_f1_i;
      taken_f2_d = pred_f1;
      lpred_f2_d = lpred_f1;
      gpred_f2_d = gpred_f1;
      ghist_f2_d = ghr_q;
      if (br_valid_f1_i) ghr_d = GHISTW'({ghr_q, pred_f1});
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      ghr_q      <= '0;
      valid_f2_q <= 1'b0;
      taken_f2_q <= 1'b0;
      lpred_f2_q <= 1'b0;
      gpred_f2_q <= 1'b0;
      ghist_f2_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ghr_q      <= ghr_d;
      valid_f2_q <= valid_f2_d;
      taken_f2_q <= taken_f2_d;
      lpred_f2_q <= lpred_f2_d;
      gpred_f2_q <= gpred_f2_d;
      ghist_f2_q <= ghist_f2_d;
    end
  end

  always_ff @(posedge clock) begin
    if (init_we) begin
      global_pht[cnt_q]              <= 2'b10;
      local_pht[cnt_q[LHISTW-1:0]]   <= 3'b100;
    end else if (rt_upd) begin
      global_pht[bpd_rt_ghist_i]     <= glb_new;
      local_pht[bpd_rt_lochist_i]    <= loc_new;
    end
  end

  assign bpd_pred_valid_f2 = valid_f2_q;
  assign bpd_pred_taken_f2 = taken_f2_q;
  assign bpd_lpred_f2      = lpred_f2_q;
  assign bpd_gpred_f2      = gpred_f2_q;
  assign bpd_ghist_f2      = ghist_f2_q;
  assign bpd_ready_o       = ready;
  assign bpd_ch_we_o       = rt_upd & (bpd_rt_lpred_i ^ bpd_rt_gpred_i);
  assign bpd_ch_brdir_o    = ready & bpd_rt_lpred_i;

endmodule

// File: tb/tb_bpd1.sv
// tb/tb_bpd1.sv - bench for bpd1: directed vector table, random stimulus vs. reference model
module tb_bpd1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        load, brv, choice, rt_we, rt_dir, rt_lp, rt_gp, fl, fl_dir;
  logic [9:0]  loch, rt_loch;
  logic [11:0] rt_gh, fl_gh;

  logic        bpd_pred_valid_f2, bpd_pred_taken_f2, bpd_lpred_f2, bpd_gpred_f2;
  logic [11:0] bpd_ghist_f2;
  logic        bpd_ch_we_o, bpd_ch_brdir_o, bpd_ready_o;

  always #5 clock = ~clock;

  bpd1 dut (
    .clock(clock), .reset_n(reset_n),
    .load_fetch_i(load), .br_valid_f1_i(brv),
    .bpd_pht_choice_f1(choice), .bpd_bht_lochist_f1(loch),
    .bpd_rt_we_i(rt_we), .bpd_rt_brdir_i(rt_dir),
    .bpd_rt_lochist_i(rt_loch), .bpd_rt_ghist_i(rt_gh),
    .bpd_rt_lpred_i(rt_lp), .bpd_rt_gpred_i(rt_gp),
    .bpd_flush_i(fl), .bpd_flush_ghist_i(fl_gh), .bpd_flush_brdir_i(fl_dir),
    .bpd_pred_valid_f2(bpd_pred_valid_f2), .bpd_pred_taken_f2(bpd_pred_taken_f2),
    .bpd_lpred_f2(bpd_lpred_f2), .bpd_gpred_f2(bpd_gpred_f2),
    .bpd_ghist_f2(bpd_ghist_f2),
    .bpd_ch_we_o(bpd_ch_we_o), .bpd_ch_brdir_o(bpd_ch_brdir_o),
    .bpd_ready_o(bpd_ready_o)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: counters as plain integers, ready as "4096 edges since release".
  int m_local[1024];
  int m_global[4096];
  int m_ghr, m_gh, m_cnt;
  bit m_ready, m_valid, m_taken, m_lp, m_gp, m_known;

  task automatic tick();
    bit lp, gp, pred, exp_we;
    #1;
    exp_we = rt_we && m_ready && (rt_lp != rt_gp);
    check("model ch_we", 32'(bpd_ch_we_o), 32'(exp_we));
    if (exp_we) check("model ch_brdir", 32'(bpd_ch_brdir_o), 32'(rt_lp));
    lp   = m_local[loch] >= 4;
    gp   = m_global[m_ghr] >= 2;
    pred = choice ? gp : lp;
    if (fl) begin
      m_valid = 0;
      m_known = 0;
      m_ghr   = ((int'(fl_gh) << 1) | int'(fl_dir)) & 32'hFFF;
    end else if (load && m_ready) begin
      m_valid = brv; m_taken = pred; m_lp = lp; m_gp = gp;
      m_gh = m_ghr; m_known = 1;
      if (brv) m_ghr = ((m_ghr << 1) | int'(pred)) & 32'hFFF;
    end
    if (rt_we && m_ready) begin
      m_local[rt_loch] = rt_dir ? ((m_local[rt_loch] < 7) ? m_local[rt_loch] + 1 : 7)
                                : ((m_local[rt_loch] > 0) ? m_local[rt_loch] - 1 : 0);
      m_global[rt_gh]  = rt_dir ? ((m_global[rt_gh] < 3) ? m_global[rt_gh] + 1 : 3)
                                : ((m_global[rt_gh] > 0) ? m_global[rt_gh] - 1 : 0);
    end
    if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 4096) begin
        m_ready = 1;
        foreach (m_local[i]) m_local[i] = 4;
        foreach (m_global[i]) m_global[i] = 2;
      end
    end
    @(posedge clock);
    #1;
    check("model ready", 32'(bpd_ready_o), 32'(m_ready));
    check("model valid_f2", 32'(bpd_pred_valid_f2), 32'(m_valid));
    if (m_known) begin
      check("model taken_f2", 32'(bpd_pred_taken_f2), 32'(m_taken));
      check("model lpred_f2", 32'(bpd_lpred_f2), 32'(m_lp));
      check("model gpred_f2", 32'(bpd_gpred_f2), 32'(m_gp));
      check("model ghist_f2", 32'(bpd_ghist_f2), 32'(m_gh));
    end
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    #1;
    check("reset valid_f2", 32'(bpd_pred_valid_f2), 0);
    check("reset taken_f2", 32'(bpd_pred_taken_f2), 0);
    check("reset lpred_f2", 32'(bpd_lpred_f2), 0);
    check("reset gpred_f2", 32'(bpd_gpred_f2), 0);
    check("reset ghist_f2", 32'(bpd_ghist_f2), 0);
    check("reset ready", 32'(bpd_ready_o), 0);
    check("reset ch_we", 32'(bpd_ch_we_o), 0);
    check("reset ch_brdir", 32'(bpd_ch_brdir_o), 0);
    m_ghr = 0; m_gh = 0; m_cnt = 0; m_ready = 0;
    m_valid = 0; m_taken = 0; m_lp = 0; m_gp = 0; m_known = 1;
    repeat (cycles) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic idle();
    load = 0; brv = 0; choice = 0; loch = '0;
    rt_we = 0; rt_dir = 0; rt_lp = 0; rt_gp = 0; rt_loch = '0; rt_gh = '0;
    fl = 0; fl_dir = 0; fl_gh = '0;
  endtask

  task automatic wait_ready(input bit with_flush);
    int n = 0;
    while (!bpd_ready_o && n < 5000) begin
      fl = with_flush && (n == 100);
      fl_gh = 12'h002;
      fl_dir = 1'b1;
      tick();
      n++;
    end
    check("ready latency", 32'(n), 4096);
  endtask

  typedef struct packed {
    logic load, brv, choice; logic [9:0] loch;
    logic rt_we, rt_dir, rt_lp, rt_gp; logic [9:0] rt_loch; logic [11:0] rt_gh;
    logic fl, fl_dir; logic [11:0] fl_gh;
    logic chk_f2, chk_data, e_valid, e_taken, e_lp, e_gp; logic [11:0] e_gh;
    logic chk_ch, e_we, e_dir;
  } vec_t;

  function automatic vec_t v_pred(bit ld, bit bv, bit ch, logic [9:0] lh,
                                  bit ev, bit et, bit elp, bit egp, logic [11:0] egh);
    vec_t v = '0;
    v.load = ld; v.brv = bv; v.choice = ch; v.loch = lh;
    v.chk_f2 = 1; v.chk_data = 1;
    v.e_valid = ev; v.e_taken = et; v.e_lp = elp; v.e_gp = egp; v.e_gh = egh;
    return v;
  endfunction

  function automatic vec_t add_ret(vec_t b, bit dir, logic [9:0] lh, logic [11:0] gh,
                                   bit lp, bit gp, bit ewe, bit edir);
    vec_t v = b;
    v.rt_we = 1; v.rt_dir = dir; v.rt_loch = lh; v.rt_gh = gh; v.rt_lp = lp; v.rt_gp = gp;
    v.chk_ch = 1; v.e_we = ewe; v.e_dir = edir;
    return v;
  endfunction

  function automatic vec_t v_flush(logic [11:0] gh, bit dir);
    vec_t v = '0;
    v.load = 1; v.brv = 1; v.fl = 1; v.fl_gh = gh; v.fl_dir = dir;
    v.chk_f2 = 1; v.e_valid = 0;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t z;
    z = '0;
    tbl.push_back(v_pred(1, 1, 0, 10'h000, 1, 1, 1, 1, 12'h000));
    tbl.push_back(v_pred(1, 1, 1, 10'h000, 1, 1, 1, 1, 12'h001));
    tbl.push_back(v_pred(1, 1, 0, 10'h000, 1, 1, 1, 1, 12'h003));
    tbl.push_back(v_pred(1, 0, 0, 10'h000, 0, 1, 1, 1, 12'h007));
    tbl.push_back(v_flush(12'h0A5, 0));
    tbl.push_back(v_pred(1, 0, 0, 10'h000, 0, 1, 1, 1, 12'h14A));
    for (int i = 0; i < 5; i++) tbl.push_back(add_ret(z, 0, 10'h003, 12'h800, 1, 1, 0, 0));
    tbl.push_back(v_pred(1, 0, 0, 10'h003, 0, 0, 0, 1, 12'h14A));
    for (int i = 0; i < 8; i++) tbl.push_back(add_ret(z, 1, 10'h003, 12'h800, 1, 1, 0, 0));
    tbl.push_back(v_pred(1, 0, 0, 10'h003, 0, 1, 1, 1, 12'h14A));
    tbl.push_back(add_ret(z, 0, 10'h3FF, 12'h801, 1, 0, 1, 1));
    tbl.push_back(add_ret(z, 1, 10'h3FE, 12'h802, 0, 1, 1, 0));
    tbl.push_back(add_ret(z, 1, 10'h3FD, 12'h803, 1, 1, 0, 0));
    tbl.push_back(v_flush(12'h000, 0));
    tbl.push_back(add_ret(v_pred(1, 0, 1, 10'h000, 0, 1, 1, 1, 12'h000), 1, 10'h200, 12'h000, 1, 1, 0, 0));
    tbl.push_back(add_ret(z, 0, 10'h200, 12'h000, 1, 1, 0, 0));
    tbl.push_back(v_pred(1, 0, 1, 10'h000, 0, 1, 1, 1, 12'h000));
    tbl.push_back(add_ret(z, 0, 10'h200, 12'h000, 1, 1, 0, 0));
    tbl.push_back(add_ret(v_pred(1, 0, 1, 10'h000, 0, 0, 1, 0, 12'h000), 1, 10'h200, 12'h000, 1, 1, 0, 0));
    tbl.push_back(v_pred(1, 0, 1, 10'h000, 0, 1, 1, 1, 12'h000));

    idle();
    #2;
    do_reset(3);
    wait_ready(0);

    foreach (tbl[i]) begin
      vec_t v = tbl[i];
      load = v.load; brv = v.brv; choice = v.choice; loch = v.loch;
      rt_we = v.rt_we; rt_dir = v.rt_dir; rt_lp = v.rt_lp; rt_gp = v.rt_gp;
      rt_loch = v.rt_loch; rt_gh = v.rt_gh;
      fl = v.fl; fl_dir = v.fl_dir; fl_gh = v.fl_gh;
      #1;
      if (v.chk_ch) begin
        check($sformatf("vec%0d ch_we", i), 32'(bpd_ch_we_o), 32'(v.e_we));
        if (v.e_we) check($sformatf("vec%0d ch_brdir", i), 32'(bpd_ch_brdir_o), 32'(v.e_dir));
      end
      tick();
      if (v.chk_f2) check($sformatf("vec%0d valid_f2", i), 32'(bpd_pred_valid_f2), 32'(v.e_valid));
      if (v.chk_data) begin
        check($sformatf("vec%0d taken_f2", i), 32'(bpd_pred_taken_f2), 32'(v.e_taken));
        check($sformatf("vec%0d lpred_f2", i), 32'(bpd_lpred_f2), 32'(v.e_lp));
        check($sformatf("vec%0d gpred_f2", i), 32'(bpd_gpred_f2), 32'(v.e_gp));
        check($sformatf("vec%0d ghist_f2", i), 32'(bpd_ghist_f2), 32'(v.e_gh));
      end
    end

    for (int i = 0; i < 1500; i++) begin
      load    = ($urandom_range(0, 3) != 0);
      brv     = 1'($urandom);
      choice  = 1'($urandom);
      loch    = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
      rt_we   = 1'($urandom);
      rt_dir  = 1'($urandom);
      rt_loch = 10'($urandom_range(0, 15));
      rt_gh   = ($urandom_range(0, 1) != 0) ? m_ghr[11:0] : 12'($urandom_range(0, 31));
      rt_lp   = 1'($urandom);
      rt_gp   = 1'($urandom);
      fl      = ($urandom_range(0, 15) == 0);
      fl_gh   = 12'($urandom);
      fl_dir  = 1'($urandom);
      tick();
    end

    idle();
    load = 1; brv = 1; rt_we = 1;
    do_reset(2);
    idle();
    rt_we = 1; rt_dir = 1; rt_loch = 10'h005; rt_gh = 12'h005; rt_lp = 1; rt_gp = 0;
    load = 1; brv = 1;
    repeat (1000) tick();
    check("mid-init ready", 32'(bpd_ready_o), 0);
    do_reset(2);
    load = 0; brv = 0;
    wait_ready(1);

    idle();
    rt_we = 1; rt_dir = 0; rt_loch = 10'h005; rt_gh = 12'h005; rt_lp = 1; rt_gp = 1;
    tick();
    idle();
    load = 1; loch = 10'h005;
    tick();
    check("reinit local counter", 32'(bpd_lpred_f2), 0);
    check("reinit global counter", 32'(bpd_gpred_f2), 0);
    check("flush during init ghist", 32'(bpd_ghist_f2), 32'h005);
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
